fir_ram_engine: RTL
===================

// Module: fir_ram_engine
// PURPOSE
//  FIR processing stage directly downstream of the AXI write path. It consumes the 16-bit samples that
//  the AXI slave has written into the input RAM. It computes y[n] = sum h[k]*x[n-k] over TAPS coefficients
//  (Q15) and writes the results into the output RAM, which the AXI read path then returns to the host.
//  The controller owns one RAM read port, one RAM write port and an internal coefficient register file.
// PARAMETERS
//  DATA_W  16  sample/coefficient/result width, signed two's complement
//  ADDR_W  13  RAM address width (matches AXI-side RAM)
//  TAPS    8   number of coefficients, power of 2, >=2
//  ACC_W   DATA_W*2+$clog2(TAPS)  accumulator width, no internal overflow
// PORTS
//  a_clk      in   1          clock, all logic on rising edge
//  a_rst_n    in   1          asynchronous reset, active-low
//  start      in   1          1-cycle run request, accepted only when busy=0
//  n_samples  in   ADDR_W     number of outputs to produce, latched on accepted start
//  in_base    in   ADDR_W     input RAM address of x[0], latched on start
//  out_base   in   ADDR_W     output RAM address of y[0], latched on start
//  coef_wr    in   1          coefficient write strobe, ignored while busy=1
//  coef_idx   in   log2(TAPS) coefficient index k
//  coef_data  in   DATA_W     h[k], signed Q15
//  in_rd      out  1          input RAM read enable
//  in_addr    out  ADDR_W     input RAM read address
//  in_data    in   DATA_W     read data, valid exactly 1 cycle after in_rd
//  out_wr     out  1          output RAM write strobe, 1 cycle per result
//  out_addr   out  ADDR_W     output RAM write address
//  out_data   out  DATA_W     result, signed Q15
//  busy       out  1          high from cycle after accepted start until done cycle inclusive
//  done       out  1          1-cycle pulse after last result written
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, accumulator 0, all h[k]=0. Reset mid-run aborts immediately, with no further
//   writes after reset release.
//  FSM: IDLE -> MAC (start && n_samples!=0) | DONE (start && n_samples==0).
//   MAC: TAPS cycles, k=0..TAPS-1. Cycle k issues in_rd=1, in_addr=in_base+n-k (mod 2^ADDR_W), only if n>=k.
//    If n<k, in_rd=0 and the term is zero. The check is on index n, never on wrapped address.
//   Product in_data*h[k] (tagged by 1-cycle-delayed valid) is accumulated the cycle after its read.
//    The acc is cleared at k=0 of each n.
//   MAC -> DRAIN (1 cycle, accumulates last product) -> WRITE (out_wr=1, out_addr=out_base+n,
//    out_data=sat(acc>>>15)). Then n++. WRITE -> MAC if n<n_samples, else DONE. DONE -> IDLE, done=1.
//  Throughput: TAPS+2 cycles per output. done is asserted N*(TAPS+2)+1 cycles after the start cycle,
//   with 1 cycle when N=0.
//  Arithmetic: full-precision signed MAC. Result = acc arithmetic-shifted right 15 (truncate).
//   Saturation: >32767 -> 0x7FFF, <-32768 -> 0x8000.
//  start while busy: ignored. coef_wr while busy: ignored, so h is frozen during a run.
//   coef_wr and start in the same IDLE cycle: both take effect, and the run uses the new h.
//  Outputs in_rd/out_wr/done are 0 in every state except as specified above.
// TESTING (TAPS=8)
//  h[0]=0x4000 rest 0, x@0x0A={0x0100,0x0200,0x0300}, in_base=0x0A, out_base=0x20, N=3 ->
//   out@0x20..22={0x0080,0x0100,0x0180}, done at start+31.
//  h[2]=0x4000 only, same x -> y={0x0000,0x0000,0x0080}. For n=0, in_rd asserted only at k=0, never addr 0x1FFF-ish.
//  All h=0x7FFF, x all 0x7FFF, N=8 -> y[0]=0x7FFE, y[7]=0x7FFF (saturated). x all 0x8000 -> y[7]=0x8000.
//  N=0 -> done 1 cycle after start, no out_wr, no in_rd.
//  Second start and coef_wr(h[0]=0) mid-run -> ignored, results unchanged. Assert a_rst_n=0 mid-run ->
//   busy=0, all outputs 0, no writes, all h read back as zero effect.
//  in_base=0x1FFE, N=4, h[0]=0x4000 -> reads wrap to 0x0000/0x0001, results correct.

Source files
------------

// File: rtl/fir_ram_engine_if.sv
// Bus bundle between the FIR engine and its host/RAM side: run control,
// coefficient load port, input RAM read port and output RAM write port.
interface fir_ram_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13,
    parameter int TAPS   = 8
);
    localparam int K_W = $clog2(TAPS);

    logic              start;
    logic [ADDR_W-1:0] n_samples;
    logic [ADDR_W-1:0] in_base;
    logic [ADDR_W-1:0] out_base;
    logic              coef_wr;
    logic [K_W-1:0]    coef_idx;
    logic [DATA_W-1:0] coef_data;
    logic              in_rd;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              out_wr;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;

    // Host / RAM side: issues run requests and coefficients, returns read data.
    modport master (
        output start, n_samples, in_base, out_base,
        output coef_wr, coef_idx, coef_data,
        output in_data,
        input  in_rd, in_addr, out_wr, out_addr, out_data, busy, done
    );

    // Engine side.
    modport slave (
        input  start, n_samples, in_base, out_base,
        input  coef_wr, coef_idx, coef_data,
        input  in_data,
        output in_rd, in_addr, out_wr, out_addr, out_data, busy, done
    );
endinterface

// File: rtl/fir_ram_engine.sv
// FIR engine: reads samples from the input RAM, computes
// y[n] = sum h[k]*x[n-k] over TAPS Q15 coefficients with a full-precision
// accumulator, and writes saturated Q15 results to the output RAM.
// One output every TAPS+2 cycles (TAPS reads, one drain, one write).
module fir_ram_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13,
    parameter int TAPS   = 8,
    parameter int ACC_W  = DATA_W*2 + $clog2(TAPS)
) (
    input  logic              a_clk,
    input  logic              a_rst_n,
    fir_ram_engine_if.slave   bus
);
    localparam int K_W    = $clog2(TAPS);
    localparam int PROD_W = 2*DATA_W;
    localparam int FRAC   = DATA_W - 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t                    r_state, w_state_nxt;
    logic [ADDR_W-1:0]         r_n_samples, r_in_base, r_out_base;
    logic [ADDR_W-1:0]         r_n;
    logic [K_W-1:0]            r_k, r_k_d;
    logic                      r_valid;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [DATA_W-1:0]  r_coef [TAPS];

    logic                      w_idle, w_n_ge_k, w_last_k, w_more;
    logic [ADDR_W:0]           w_n_inc;
    logic [ADDR_W-1:0]         w_rd_addr;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext, w_shift;
    logic [DATA_W-1:0]         w_sat;
    logic                      w_in_rd, w_out_wr, w_done, w_busy;
    logic [ADDR_W-1:0]         w_in_addr, w_out_addr;
    logic [DATA_W-1:0]         w_out_data;

    assign w_idle     = (r_state == S_IDLE);
    // Tap validity is decided on the sample index, so a wrapped address never leaks in.
    assign w_n_ge_k   = (r_n >= ADDR_W'(r_k));
    assign w_last_k   = (r_k == K_W'(TAPS-1));
    assign w_n_inc    = {1'b0, r_n} + {{ADDR_W{1'b0}}, 1'b1};
    assign w_more     = (w_n_inc < {1'b0, r_n_samples});
    assign w_rd_addr  = r_in_base + r_n - ADDR_W'(r_k);
    // The read issued last cycle is paired with the coefficient of its tap.
    assign w_prod     = $signed(bus.in_data) * r_coef[r_k_d];
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_shift    = r_acc >>> FRAC;

    // Clamp the truncated Q15 result to the representable range.
    always_comb begin
        if (w_shift > SAT_MAX)
            w_sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (w_shift < SAT_MIN)
            w_sat = {1'b1, {(DATA_W-1){1'b0}}};
        else
            w_sat = w_shift[DATA_W-1:0];
    end

    // FSM state register.
    always_ff @(posedge a_clk or negedge a_rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!a_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and per-state RAM strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_state_nxt = r_state;
        w_in_rd     = 1'b0;
        w_in_addr   = '0;
        w_out_wr    = 1'b0;
        w_out_addr  = '0;
        w_out_data  = '0;
        w_done      = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start)
                    w_state_nxt = (bus.n_samples != '0) ? S_MAC : S_DONE;
            end
            S_MAC: begin
                if (w_n_ge_k) begin
                    w_in_rd   = 1'b1;
                    w_in_addr = w_rd_addr;
                end
                if (w_last_k) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: w_state_nxt = S_WRITE;
            S_WRITE: begin
                w_out_wr    = 1'b1;
                w_out_addr  = r_out_base + r_n;
                w_out_data  = w_sat;
                w_state_nxt = w_more ? S_MAC : S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Coefficient file; writable only while idle so h is frozen during a run.
    always_ff @(posedge a_clk or negedge a_rst_n) begin
        // NOTE: this small register file is reset explicitly because h must read as zero after reset.
        if (!a_rst_n) begin
            for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
        end else if (w_idle && bus.coef_wr) begin
            r_coef[bus.coef_idx] <= $signed(bus.coef_data);
        end
    end

    // Run parameters and sample/tap counters.
    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_n_samples <= '0;
            r_in_base   <= '0;
            r_out_base  <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_k_d       <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= w_in_rd;
            r_k_d   <= r_k;
            if (w_idle && bus.start) begin
                r_n_samples <= bus.n_samples;
                r_in_base   <= bus.in_base;
                r_out_base  <= bus.out_base;
                r_n         <= '0;
                r_k         <= '0;
            end
            if (r_state == S_MAC)   r_k <= r_k + K_W'(1);
            if (r_state == S_WRITE) r_n <= w_n_inc[ADDR_W-1:0];
        end
    end

    // Accumulator: cleared on the first tap of each output, adds each returned product.
    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n)                             r_acc <= '0;
        else if (r_state == S_MAC && r_k == '0)   r_acc <= '0;
        else if (r_valid)                         r_acc <= r_acc + w_prod_ext;
    end

    assign bus.in_rd    = w_in_rd;
    assign bus.in_addr  = w_in_addr;
    assign bus.out_wr   = w_out_wr;
    assign bus.out_addr = w_out_addr;
    assign bus.out_data = w_out_data;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
endmodule
